// File: rtl/uart_mem_master.sv
// CPU-side master of the UART memory link: serializes one request, waits for the reply.
// Define MEM_TIMEOUT_EN to abort a WAIT that receives no reply byte for TIMEOUT_CYCLES cycles.
module uart_mem_master #(
    parameter int CLKS_PER_BIT   = 434,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_mask,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        Tx,
    input  logic        Rx
);
    localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    if (CLKS_PER_BIT < 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_mem_master: CLKS_PER_BIT must be >= 4 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
    state_t state_q, state_d;

    logic          run_q;
    logic          we_q, we_d;
    logic [71:0]   pkt_q, pkt_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [3:0]    tx_byte_q, tx_byte_d;
    logic          tx_q, tx_d;
    logic [9:0]    tx_frame;
    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic          rx_busy_q, rx_busy_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic [2:0]    rx_nbytes_q, rx_nbytes_d;
    logic [31:0]   rx_word_q, rx_word_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          byte_done;
    logic          timeout;

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = '0;
        if (state_q == WAIT && !byte_done) tmo_d = tmo_q + 1'b1;
    end

    assign timeout = (state_q == WAIT) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        pkt_d       = pkt_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_byte_d   = tx_byte_q;
        rx_busy_d   = 1'b0;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_sh_d     = rx_sh_q;
        rx_nbytes_d = rx_nbytes_q;
        rx_word_d   = rx_word_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        byte_done   = 1'b0;

        // Receiver runs only in WAIT; rx_bit 0 is the start bit, 9 the stop bit.
        if (state_q == WAIT) begin
            if (!rx_busy_q) begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_busy_d = 1'b1;
                    rx_cnt_d  = '0;
                    rx_bit_d  = 4'd0;
                end
            end else begin
                rx_busy_d = 1'b1;
                rx_cnt_d  = rx_cnt_q + 1'b1;
                if (rx_bit_q == 4'd0) begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_d = '0;
                        if (rx_s2_q) rx_busy_d = 1'b0;
                        else         rx_bit_d  = 4'd1;
                    end
                end else if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_bit_q == 4'd9) begin
                        rx_busy_d   = 1'b0;
                        byte_done   = 1'b1;
                        if (!rx_s2_q) err_d = 1'b1;
                        rx_word_d   = {rx_sh_q, rx_word_q[31:8]};
                        rx_nbytes_d = rx_nbytes_q + 3'd1;
                    end else begin
                        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (run_q && req_valid) begin
                    state_d     = SEND;
                    we_d        = req_we;
                    pkt_d       = {req_wdata, req_addr, req_we, 3'b000, req_we ? req_mask : 4'h0};
                    tx_cnt_d    = '0;
                    tx_bit_d    = 4'd0;
                    tx_byte_d   = 4'd0;
                    rx_nbytes_d = 3'd0;
                    err_d       = 1'b0;
                end
            end
            SEND: begin
                tx_cnt_d = tx_cnt_q + 1'b1;
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        tx_bit_d  = 4'd0;
                        tx_byte_d = tx_byte_q + 4'd1;
                        pkt_d     = {8'h00, pkt_q[71:8]};
                        if (tx_byte_q == (we_q ? 4'd8 : 4'd4)) state_d = WAIT;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end
            end
            WAIT: begin
                if (byte_done && (rx_nbytes_q + 3'd1 == (we_q ? 3'd1 : 3'd4))) begin
                    state_d = DONE;
                    if (we_q) begin
                        if (rx_sh_q != 8'hAA) err_d = 1'b1;
                    end else begin
                        rdata_d = rx_word_d;
                    end
                end else if (timeout) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Tx is registered from next-state values so the start bit leaves on the accept edge.
        tx_frame = {1'b1, pkt_d[7:0], 1'b0};
        tx_d     = (state_d == SEND) ? tx_frame[tx_bit_d] : 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            run_q       <= 1'b0;
            we_q        <= 1'b0;
            pkt_q       <= '0;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_byte_q   <= '0;
            tx_q        <= 1'b1;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_busy_q   <= 1'b0;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_sh_q     <= '0;
            rx_nbytes_q <= '0;
            rx_word_q   <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= 1'b1;
            we_q        <= we_d;
            pkt_q       <= pkt_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_byte_q   <= tx_byte_d;
            tx_q        <= tx_d;
            rx_s1_q     <= Rx;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            rx_busy_q   <= rx_busy_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_sh_q     <= rx_sh_d;
            rx_nbytes_q <= rx_nbytes_d;
            rx_word_q   <= rx_word_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign req_ready  = run_q && (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign Tx         = tx_q;
endmodule

// File: tb/tb_uart_mem_master.sv
// Scoreboard bench for uart_mem_master: Tx bytes and responses are checked by monitors
// against expectations queued when each request is issued.
`timescale 1ns/1ps
module tb_uart_mem_master;
    localparam int CPB = 4;
    localparam int TMO = 200;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [3:0]  req_mask = 4'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        Rx = 1'b1;
    logic        req_ready, resp_valid, resp_err, Tx;
    logic [31:0] resp_rdata;

    uart_mem_master #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_mask(req_mask), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .Tx(Tx), .Rx(Rx)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_vec = 0;
    int n_fail = 0;
    int resp_seen = 0;
    int last_resp_cyc = -1;
    int last_byte_start = -1;
    logic [7:0]  tx_exp[$];
    logic [32:0] resp_exp[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic exp_tx(input int n, input logic [71:0] seq);
        for (int i = 0; i < n; i++) tx_exp.push_back(seq[71-8*i -: 8]);
    endtask

    // Tx monitor: every bit must hold for exactly CPB cycles.
    initial begin : tx_mon
        logic [7:0] b;
        logic [7:0] e;
        logic ok, aborted;
        int st;
        forever begin
            @(negedge CLK);
            if (!RST && Tx === 1'b0) begin
                st = cyc; b = '0; ok = 1'b1; aborted = 1'b0;
                for (int k = 1; k < 10*CPB; k++) begin
                    @(negedge CLK);
                    if (RST) aborted = 1'b1;
                    if (k / CPB == 0) begin
                        if (Tx !== 1'b0) ok = 1'b0;
                    end else if (k / CPB == 9) begin
                        if (Tx !== 1'b1) ok = 1'b0;
                    end else if (k % CPB == 0) begin
                        b[k/CPB-1] = Tx;
                    end else if (Tx !== b[k/CPB-1]) begin
                        ok = 1'b0;
                    end
                end
                if (!aborted) begin
                    last_byte_start = st;
                    if (tx_exp.size() == 0) begin
                        n_vec++; n_fail++;
                        $display("FAIL tx_unexpected: byte 0x%02h, none expected", b);
                    end else begin
                        e = tx_exp.pop_front();
                        chk("tx_byte {frame_ok,byte}", {55'd0, ok, b}, {55'd0, 1'b1, e});
                    end
                end
            end
        end
    end

    initial begin : resp_mon
        logic [32:0] e;
        forever begin
            @(negedge CLK);
            if (!RST && resp_valid === 1'b1) begin
                resp_seen++;
                last_resp_cyc = cyc;
                if (resp_exp.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL resp_unexpected: err=%0b rdata=0x%08h, none expected", resp_err, resp_rdata);
                end else begin
                    e = resp_exp.pop_front();
                    chk("resp {err,rdata}", {31'd0, resp_err, resp_rdata}, {31'd0, e});
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [3:0] mask, input logic [31:0] addr,
                         input logic [31:0] wdata);
        @(negedge CLK);
        req_valid = 1'b1; req_we = we; req_mask = mask; req_addr = addr; req_wdata = wdata;
    endtask

    // Called at a negedge; returns the cycle in which req_ready was seen with req_valid high.
    task automatic wait_accept(output int acc);
        int n;
        n = 0; acc = -1;
        while (acc < 0 && n < 3000) begin
            if (req_ready === 1'b1) acc = cyc;
            else begin @(negedge CLK); n++; end
        end
        if (acc < 0) begin
            n_vec++; n_fail++;
            $display("FAIL accept_wait: req_ready low for %0d cycles, required high", n);
        end else begin
            @(posedge CLK);
        end
    endtask

    // Scramble the request fields after acceptance; the latched packet must not change.
    task automatic release_req;
        @(negedge CLK);
        req_valid = 1'b0; req_we = ~req_we; req_mask = 4'h0;
        req_addr = 32'hBAD0_BAD0; req_wdata = 32'h5A5A_5A5A;
    endtask

    task automatic wait_until(input int t);
        @(negedge CLK);
        while (cyc < t) @(negedge CLK);
    endtask

    task automatic wait_resp(input int n);
        int k;
        k = 0;
        while (resp_seen < n && k < 3000) begin @(negedge CLK); k++; end
        if (resp_seen < n) begin
            n_vec++; n_fail++;
            $display("FAIL resp_wait: %0d responses seen, required %0d", resp_seen, n);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        Rx = 1'b0; repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin Rx = b[i]; repeat (CPB) @(negedge CLK); end
        Rx = stop; repeat (CPB) @(negedge CLK);
        Rx = 1'b1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int a, a2, nresp, hi;
        nresp = 0;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("reset Tx", {63'd0, Tx}, 64'd1);
        chk("reset resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("reset req_ready", {63'd0, req_ready}, 64'd0);
        chk("reset resp_rdata", {32'd0, resp_rdata}, 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("req_ready after release", {63'd0, req_ready}, 64'd1);

        // Read 0x1004; mask must be forced to 0 in the command byte
        issue(1'b0, 4'hF, 32'h0000_1004, 32'hFFFF_FFFF);
        exp_tx(5, {8'h00, 8'h04, 8'h10, 8'h00, 8'h00, 32'h0});
        resp_exp.push_back({1'b0, 32'h1234_5678}); nresp++;
        wait_accept(a); release_req;
        wait_until(a + 204);
        chk("read last Tx byte start", 64'(last_byte_start), 64'(a + 1 + 160));
        send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
        wait_resp(nresp);

        // Write with success reply, then with a bad reply byte
        for (int r = 0; r < 2; r++) begin
            issue(1'b1, 4'h3, 32'h0000_0020, 32'hDEAD_BEEF);
            exp_tx(9, {8'h83, 8'h20, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
            resp_exp.push_back({(r == 1), 32'h1234_5678}); nresp++;
            wait_accept(a); release_req;
            wait_until(a + 364);
            send_byte((r == 0) ? 8'hAA : 8'h55, 1'b1);
            wait_resp(nresp);
        end

        // Read with a one-cycle glitch on Rx before the reply
        issue(1'b0, 4'h0, 32'hA5C3_0F81, 32'h0);
        exp_tx(5, {8'h00, 8'h81, 8'h0F, 8'hC3, 8'hA5, 32'h0});
        resp_exp.push_back({1'b0, 32'h4433_2211}); nresp++;
        wait_accept(a); release_req;
        wait_until(a + 204);
        Rx = 1'b0; @(negedge CLK); Rx = 1'b1; repeat (8) @(negedge CLK);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
        wait_resp(nresp);

        // Write whose reply byte has a framing error (stop bit low)
        issue(1'b1, 4'hF, 32'h0000_0300, 32'h0000_00FF);
        exp_tx(9, {8'h8F, 8'h00, 8'h03, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00});
        resp_exp.push_back({1'b1, 32'h4433_2211}); nresp++;
        wait_accept(a); release_req;
        wait_until(a + 364);
        send_byte(8'hAA, 1'b0);
        wait_resp(nresp);

        // Back-to-back with req_valid held; fields change during the first SEND
        issue(1'b0, 4'h0, 32'h0000_0100, 32'h0);
        exp_tx(5, {8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 32'h0});
        resp_exp.push_back({1'b0, 32'hDEAD_BEEF}); nresp++;
        wait_accept(a);
        @(negedge CLK);
        req_we = 1'b1; req_mask = 4'hC; req_addr = 32'h0000_0044; req_wdata = 32'h0102_0304;
        exp_tx(9, {8'h8C, 8'h44, 8'h00, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01});
        resp_exp.push_back({1'b0, 32'hDEAD_BEEF}); nresp++;
        fork
            begin
                wait_until(a + 204);
                send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1);
                send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
            end
            begin
                @(negedge CLK);
                wait_accept(a2);
            end
        join
        chk("b2b second accept cycle", 64'(a2), 64'(last_resp_cyc + 1));
        release_req;
        wait_until(a2 + 364);
        send_byte(8'hAA, 1'b1);
        wait_resp(nresp);

`ifdef MEM_TIMEOUT_EN
        // No reply: timeout 200 cycles after SEND ends
        issue(1'b0, 4'h0, 32'h0000_0008, 32'h0);
        exp_tx(5, {8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 32'h0});
        resp_exp.push_back({1'b1, 32'hDEAD_BEEF}); nresp++;
        wait_accept(a); release_req;
        wait_resp(nresp);
        chk("timeout resp cycle", 64'(last_resp_cyc), 64'(a + 1 + 200 + TMO));
`endif

        // Reset during SEND: first byte completes, the rest is cut off
        issue(1'b1, 4'hF, 32'h1234_5678, 32'hCAFE_F00D);
        exp_tx(1, {8'h8F, 64'h0});
        wait_accept(a); release_req;
        wait_until(a + 50);
        @(posedge CLK); #3; RST = 1'b1;
        @(negedge CLK);
        chk("mid-reset Tx", {63'd0, Tx}, 64'd1);
        chk("mid-reset req_ready", {63'd0, req_ready}, 64'd0);
        RST = 1'b0;
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (Tx === 1'b1) hi++;
        end
        chk("Tx idle after reset (cycles high)", 64'(hi), 64'd100);
        chk("resp_rdata after reset", {32'd0, resp_rdata}, 64'd0);
        chk("Tx bytes outstanding", 64'(tx_exp.size()), 64'd0);
        chk("responses seen", 64'(resp_seen), 64'(nresp));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
